// File: rtl/avalon_pio_out_dbuf.sv
// Avalon-MM PIO output with shadow/active double buffer, zero-wait reads, commit pulse and counter.
// Optional commit interrupt (irq port, register 6) is built when PIO_DBUF_IRQ_EN is defined.
module avalon_pio_out_dbuf #(
  parameter int                DATA_W      = 24,
  parameter logic [DATA_W-1:0] RESET_VALUE = '0,
  parameter int                SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic              update_sync,
  output logic [DATA_W-1:0] out_port,
`ifdef PIO_DBUF_IRQ_EN
  output logic              irq,
`endif
  output logic              commit_pulse
);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_SHADOW = 3'd1;
  localparam logic [2:0] A_OUTSET = 3'd2;
  localparam logic [2:0] A_OUTCLR = 3'd3;
  localparam logic [2:0] A_CTRL   = 3'd4;
  localparam logic [2:0] A_STATUS = 3'd5;
  localparam logic [2:0] A_IRQ    = 3'd6;

  logic [DATA_W-1:0]      shadow, shadow_nxt, active, active_nxt, wd;
  logic                   sync_mode, pending;
  logic [15:0]            commit_cnt;
  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   edge_ff, sync_rise;
  logic                   wr, data_wr, ctrl_wr, force_wr, leave_commit;
  logic                   imm_commit, sync_commit, commit;
  logic                   unused_wd;

  assign wd        = writedata[DATA_W-1:0];
  assign unused_wd = ^writedata;
  assign wr        = chipselect & ~write_n;
  assign data_wr   = wr & ((address == A_DATA) | (address == A_OUTSET) | (address == A_OUTCLR));
  assign ctrl_wr   = wr & (address == A_CTRL);
  assign force_wr  = ctrl_wr & writedata[1];
  assign sync_rise = sync_ff[SYNC_STAGES-1] & ~edge_ff;

  // Dropping out of sync mode flushes any pending shadow so nothing is stranded.
  assign leave_commit = ctrl_wr & sync_mode & ~writedata[0] & pending;
  assign imm_commit   = data_wr & ~sync_mode;
  assign sync_commit  = sync_mode & (sync_rise | force_wr | leave_commit);
  assign commit       = imm_commit | sync_commit;

  always_comb begin
    shadow_nxt = shadow;
    if (data_wr) begin
      case (address)
        A_DATA:   shadow_nxt = wd;
        A_OUTSET: shadow_nxt = shadow | wd;
        A_OUTCLR: shadow_nxt = shadow & ~wd;
        default:  shadow_nxt = shadow;
      endcase
    end
  end

  // A sync-mode commit takes the registered shadow, so a same-cycle write lands in the next frame.
  assign active_nxt = imm_commit ? shadow_nxt : shadow;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow       <= RESET_VALUE;
      active       <= RESET_VALUE;
      sync_mode    <= 1'b0;
      pending      <= 1'b0;
      commit_cnt   <= 16'd0;
      commit_pulse <= 1'b0;
      sync_ff      <= '0;
      edge_ff      <= 1'b0;
    end else begin
      shadow       <= shadow_nxt;
      sync_ff      <= {sync_ff[SYNC_STAGES-2:0], update_sync};
      edge_ff      <= sync_ff[SYNC_STAGES-1];
      commit_pulse <= commit;
      pending      <= (pending & ~commit) | (sync_mode & data_wr);
      if (ctrl_wr) sync_mode <= writedata[0];
      if (commit) begin
        active     <= active_nxt;
        commit_cnt <= commit_cnt + 16'd1;
      end
    end
  end

  assign out_port = active;

`ifdef PIO_DBUF_IRQ_EN
  logic commit_irq_en, commit_flag;

  // A commit wins over a same-cycle write-1-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      commit_irq_en <= 1'b0;
      commit_flag   <= 1'b0;
      irq           <= 1'b0;
    end else begin
      if (wr && address == A_IRQ) commit_irq_en <= writedata[0];
      commit_flag <= commit | (commit_flag & ~(wr && address == A_IRQ && writedata[1]));
      irq         <= commit_irq_en & commit_flag;
    end
  end
`endif

  always_comb begin
    readdata = 32'd0;
    case (address)
      A_DATA:   readdata[DATA_W-1:0] = active;
      A_SHADOW: readdata[DATA_W-1:0] = shadow;
      A_CTRL:   readdata[0] = sync_mode;
      A_STATUS: readdata = {commit_cnt, 15'd0, pending};
`ifdef PIO_DBUF_IRQ_EN
      A_IRQ:    readdata[1:0] = {commit_flag, commit_irq_en};
`endif
      default:  readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_avalon_pio_out_dbuf.sv
// Directed table-driven bench for avalon_pio_out_dbuf plus hand-timed sync, collision, reset and wrap sequences.
module tb_avalon_pio_out_dbuf;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        update_sync = 1'b0;
  logic [23:0] out_port;
  logic        commit_pulse;
`ifdef PIO_DBUF_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;

  avalon_pio_out_dbuf dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address      (address),
    .chipselect   (chipselect),
    .write_n      (write_n),
    .writedata    (writedata),
    .readdata     (readdata),
    .update_sync  (update_sync),
    .out_port     (out_port),
`ifdef PIO_DBUF_IRQ_EN
    .irq          (irq),
`endif
    .commit_pulse (commit_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic w, input logic [2:0] a, input logic [31:0] d, input logic [31:0] e);
    vec_t r;
    r.wr = w; r.addr = a; r.data = d; r.exp = e;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic do_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  // Writes check out_port after the write edge; reads check readdata.
  task automatic run_vecs(input string tag);
    logic [31:0] got;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data);
        chk($sformatf("%s_v%0d_out", tag, i), 32'(out_port), vecs[i].exp);
      end else begin
        do_read(vecs[i].addr, got);
        chk($sformatf("%s_v%0d_rd%0d", tag, i, vecs[i].addr), got, vecs[i].exp);
      end
    end
    vecs.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    repeat (2) @(negedge clk);
    chk("reset_out", 32'(out_port), 32'h0);
    chk("reset_pulse", 32'(commit_pulse), 32'h0);
    reset_n = 1'b1;

    // Reset reads, immediate write, then sync-mode staging.
    vecs.push_back(v(0, 3'd0, 0, 32'h0));
    vecs.push_back(v(0, 3'd1, 0, 32'h0));
    vecs.push_back(v(0, 3'd5, 0, 32'h0));
    vecs.push_back(v(1, 3'd0, 32'h123456, 32'h123456));
    run_vecs("imm");
    chk("imm_pulse_hi", 32'(commit_pulse), 32'h1);
    @(posedge clk); #1;
    chk("imm_pulse_lo", 32'(commit_pulse), 32'h0);

    vecs.push_back(v(0, 3'd5, 0, 32'h0001_0000));
    vecs.push_back(v(1, 3'd4, 32'h1, 32'h123456));
    vecs.push_back(v(1, 3'd0, 32'hFFABCDEF, 32'h123456));
    vecs.push_back(v(0, 3'd5, 0, 32'h0001_0001));
    vecs.push_back(v(0, 3'd1, 0, 32'hABCDEF));
    vecs.push_back(v(0, 3'd4, 0, 32'h1));
    vecs.push_back(v(0, 3'd7, 0, 32'h0));
    run_vecs("sync");

    // update_sync rising edge reaches out_port on the third edge.
    @(negedge clk);
    update_sync = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("lat_edge%0d", k), 32'(out_port), (k < 3) ? 32'h123456 : 32'hABCDEF);
    end
    chk("lat_pulse", 32'(commit_pulse), 32'h1);

    // update_sync stays high: no further commits.
    vecs.push_back(v(0, 3'd5, 0, 32'h0002_0000));
    vecs.push_back(v(1, 3'd0, 32'h0000F0, 32'hABCDEF));
    vecs.push_back(v(1, 3'd2, 32'h00000F, 32'hABCDEF));
    vecs.push_back(v(1, 3'd3, 32'h000030, 32'hABCDEF));
    vecs.push_back(v(0, 3'd1, 0, 32'h0000CF));
    vecs.push_back(v(0, 3'd2, 0, 32'h0));
    vecs.push_back(v(1, 3'd4, 32'h3, 32'h0000CF));
    vecs.push_back(v(0, 3'd5, 0, 32'h0003_0000));
    vecs.push_back(v(0, 3'd4, 0, 32'h1));
    run_vecs("setclr");

    // Collision: synchronised edge and a data write on the same clock edge.
    @(negedge clk);
    update_sync = 1'b0;
    repeat (4) @(posedge clk);
    do_write(3'd0, 32'h222222);
    chk("coll_pre", 32'(out_port), 32'h0000CF);
    @(negedge clk);
    update_sync = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chipselect = 1'b1; write_n = 1'b0; address = 3'd0; writedata = 32'h111111;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
    chk("coll_out", 32'(out_port), 32'h222222);
    vecs.push_back(v(0, 3'd1, 0, 32'h111111));
    vecs.push_back(v(0, 3'd5, 0, 32'h0004_0001));
    vecs.push_back(v(1, 3'd4, 32'h0, 32'h111111));
    vecs.push_back(v(0, 3'd5, 0, 32'h0005_0000));
    vecs.push_back(v(1, 3'd4, 32'h1, 32'h111111));
    vecs.push_back(v(0, 3'd5, 0, 32'h0005_0000));
    vecs.push_back(v(1, 3'd0, 32'h555555, 32'h111111));
    run_vecs("mode");

    // Asynchronous reset while a shadow value is pending.
    #2;
    reset_n = 1'b0;
    address = 3'd5;
    #1;
    chk("arst_out", 32'(out_port), 32'h0);
    chk("arst_status", readdata, 32'h0);
    address = 3'd1;
    #1;
    chk("arst_shadow", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    update_sync = 1'b0;

    // Commit counter wrap via back-to-back FORCE writes.
    do_write(3'd4, 32'h1);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = 3'd4; writedata = 32'h3;
    repeat (65535) @(posedge clk);
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    do_read(3'd5, got);
    chk("wrap_ffff", got, 32'hFFFF_0000);
    do_write(3'd4, 32'h3);
    do_read(3'd5, got);
    chk("wrap_zero", got, 32'h0);

`ifdef PIO_DBUF_IRQ_EN
    do_read(3'd6, got);
    chk("irq_flag_set", got, 32'h2);
    chk("irq_masked", 32'(irq), 32'h0);
    do_write(3'd6, 32'h3);
    do_read(3'd6, got);
    chk("irq_flag_clr", got, 32'h1);
    do_write(3'd4, 32'h3);
    @(posedge clk); #1;
    chk("irq_rise", 32'(irq), 32'h1);
    do_write(3'd6, 32'h3);
    @(posedge clk); #1;
    chk("irq_fall", 32'(irq), 32'h0);
`else
    do_read(3'd6, got);
    chk("reg6_zero", got, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
